// File: rtl/cube_pkg.sv
// cube_pkg: shared constants, rotation encodings, inverse helper and sequencer state type
package cube_pkg;
    localparam int NUM_FACES         = 6;
    localparam int STICKERS_PER_FACE = 9;
    localparam int CUBE_STICKERS     = 54;

    localparam logic [2:0] FACE_U   = 3'd0;
    localparam logic [2:0] FACE_R   = 3'd1;
    localparam logic [2:0] FACE_F   = 3'd2;
    localparam logic [2:0] FACE_D   = 3'd3;
    localparam logic [2:0] FACE_L   = 3'd4;
    localparam logic [2:0] FACE_B   = 3'd5;
    localparam logic [2:0] FACE_MAX = FACE_B;

    localparam logic [1:0] ROT_NONE = 2'd0;
    localparam logic [1:0] ROT_CW   = 2'd1;
    localparam logic [1:0] ROT_CCW  = 2'd2;
    localparam logic [1:0] ROT_DBL  = 2'd3;

    localparam logic [2:0] QT_NONE = 3'd0;
    localparam logic [2:0] QT_CW   = 3'd1;
    localparam logic [2:0] QT_DBL  = 3'd2;
    localparam logic [2:0] QT_CCW  = 3'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_APPLY,
        ST_SCRAMBLE,
        ST_VERIFY
    } state_t;

    function automatic logic [1:0] inv_rot(input logic [1:0] r);
        return (r == ROT_CW) ? ROT_CCW : (r == ROT_CCW) ? ROT_CW : r;
    endfunction

    function automatic logic [2:0] user_qt(input logic [1:0] r);
        return (r == ROT_CW) ? QT_CW : (r == ROT_CCW) ? QT_CCW : (r == ROT_DBL) ? QT_DBL : QT_NONE;
    endfunction

    // moveGenerator code: 0=CW, 1=CCW, 2=double, 3=CW
    function automatic logic [2:0] rand_qt(input logic [1:0] r);
        return (r == 2'd1) ? QT_CCW : (r == 2'd2) ? QT_DBL : QT_CW;
    endfunction
endpackage

// File: rtl/cube_solved_check.sv
// cube_solved_check: flags a cube whose every sticker matches its face centre
module cube_solved_check
    import cube_pkg::*;
#(
    parameter int STICKER_W = 3
) (
    input  logic [CUBE_STICKERS*STICKER_W-1:0] cube,
    output logic                               solved
);
    // compare each sticker against the centre of its own face
    always_comb begin
        solved = 1'b1;
        for (int f = 0; f < NUM_FACES; f++)
            for (int s = 0; s < STICKERS_PER_FACE; s++)
                if (cube[(f*STICKERS_PER_FACE+s)*STICKER_W +: STICKER_W] !=
                    cube[(f*STICKERS_PER_FACE+4)*STICKER_W +: STICKER_W])
                    solved = 1'b0;
    end
endmodule

// File: rtl/cube_move_sequencer.sv
// cube_move_sequencer: owns the cube state and sequences scramble, user and undo moves through cubeState
module cube_move_sequencer
    import cube_pkg::*;
#(
    parameter int STICKER_W    = 3,
    parameter int SCRAMBLE_LEN = 30,
    parameter int HIST_DEPTH   = 16,
    parameter int CNT_W        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_scramble,
    input  logic                               move_valid,
    input  logic [2:0]                         move_face,
    input  logic [1:0]                         move_rot,
    output logic                               move_ready,
    input  logic                               undo_req,
    input  logic [2:0]                         rand_face,
    input  logic [1:0]                         rand_rot,
    output logic [5:0]                         eng_face,
    output logic [2:0]                         eng_rot,
    input  logic [CUBE_STICKERS*STICKER_W-1:0] cube_next,
    output logic [CUBE_STICKERS*STICKER_W-1:0] cube_state,
    output logic                               solved,
    output logic                               busy,
    output logic                               err,
    output logic [CNT_W-1:0]                   move_count,
    output logic [$clog2(HIST_DEPTH):0]        hist_level
);
    localparam int VW = CUBE_STICKERS * STICKER_W;
    localparam int HW = $clog2(HIST_DEPTH);

    state_t         state, state_nx;
    logic           scr_flag;
    logic [7:0]     scr_cnt;
    logic [2:0]     lat_face;
    logic [1:0]     lat_rot;
    logic           lat_undo;
    logic [4:0]     hist [HIST_DEPTH];
    logic [HW-1:0]  top;
    logic [HW-1:0]  top_m1;
    logic [VW-1:0]  solved_cube;
    logic           chk_solved;
    logic           in_ready, take_scr, take_undo, undo_ok, accept, go_move, rand_ok, scr_done;

    assign in_ready   = (state == ST_READY);
    assign move_ready = in_ready & ~start_scramble & ~undo_req;
    assign busy       = ~in_ready;
    assign take_scr   = in_ready & start_scramble;
    assign take_undo  = in_ready & ~start_scramble & undo_req;
    assign undo_ok    = (hist_level != '0);
    assign accept     = move_valid & move_ready;
    assign go_move    = accept & (move_face <= FACE_MAX) & (move_rot != ROT_NONE);
    assign rand_ok    = (rand_face <= FACE_MAX);
    assign scr_done   = rand_ok & (scr_cnt == 8'(SCRAMBLE_LEN - 1));
    assign top_m1     = top - 1'b1;

    cube_solved_check #(.STICKER_W(STICKER_W)) u_chk (
        .cube  (cube_state),
        .solved(chk_solved)
    );

    // reference solved pattern: face f carries colour f on all nine stickers
    always_comb begin
        solved_cube = '0;
        for (int i = 0; i < CUBE_STICKERS; i++)
            solved_cube[i*STICKER_W +: STICKER_W] = STICKER_W'(i / STICKERS_PER_FACE);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nx;

    // next state and engine drive; the engine only sees a move in APPLY and SCRAMBLE
    always_comb begin
        state_nx = state;
        eng_face = '0;
        eng_rot  = '0;
        case (state)
            ST_INIT:     state_nx = scr_flag ? ST_SCRAMBLE : ST_VERIFY;
            ST_READY:    state_nx = take_scr ? ST_INIT :
                                    ((take_undo & undo_ok) | go_move) ? ST_APPLY : ST_READY;
            ST_APPLY: begin
                eng_face = {3'b000, lat_face};
                eng_rot  = user_qt(lat_rot);
                state_nx = ST_VERIFY;
            end
            ST_SCRAMBLE: begin
                eng_face = {3'b000, rand_face};
                eng_rot  = rand_qt(rand_rot);
                state_nx = scr_done ? ST_VERIFY : ST_SCRAMBLE;
            end
            ST_VERIFY:   state_nx = ST_READY;
            default:     state_nx = ST_INIT;
        endcase
    end

    // cube, bookkeeping and latched-move registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cube_state <= '0;
            solved     <= 1'b0;
            err        <= 1'b0;
            move_count <= '0;
            hist_level <= '0;
            top        <= '0;
            scr_flag   <= 1'b0;
            scr_cnt    <= '0;
            lat_face   <= '0;
            lat_rot    <= '0;
            lat_undo   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_INIT: begin
                    cube_state <= solved_cube;
                    move_count <= '0;
                    hist_level <= '0;
                    top        <= '0;
                    scr_cnt    <= '0;
                end
                ST_READY: begin
                    if (take_scr) scr_flag <= 1'b1;
                    else if (take_undo) begin
                        if (!undo_ok) err <= 1'b1;
                        else begin
                            lat_face   <= hist[top_m1][4:2];
                            lat_rot    <= inv_rot(hist[top_m1][1:0]);
                            lat_undo   <= 1'b1;
                            top        <= top_m1;
                            hist_level <= hist_level - 1'b1;
                        end
                    end else if (accept) begin
                        if (move_face > FACE_MAX) err <= 1'b1;
                        else begin
                            lat_face <= move_face;
                            lat_rot  <= move_rot;
                            lat_undo <= 1'b0;
                        end
                    end
                end
                ST_APPLY: begin
                    cube_state <= cube_next;
                    if (lat_undo) move_count <= (move_count == '0) ? move_count : move_count - 1'b1;
                    else begin
                        top        <= top + 1'b1;
                        hist_level <= (hist_level == (HW+1)'(HIST_DEPTH)) ? hist_level : hist_level + 1'b1;
                        move_count <= (&move_count) ? move_count : move_count + 1'b1;
                    end
                end
                ST_SCRAMBLE: if (rand_ok) begin
                    cube_state <= cube_next;
                    scr_cnt    <= scr_cnt + 1'b1;
                    if (scr_done) scr_flag <= 1'b0;
                end
                ST_VERIFY: solved <= chk_solved;
                default: ;
            endcase
        end

    // history ring: a push when full overwrites the oldest slot because top simply wraps
    always_ff @(posedge clk)
        if (state == ST_APPLY && !lat_undo) hist[top] <= {lat_face, lat_rot};
endmodule

// File: doc/cube_move_sequencer.md
Name: cube_move_sequencer

Overview:
Parametrised successor to the board-level cube driver's control core. It owns the flattened cube state and sequences three kinds of move through the existing combinational move engine (cubeState):
- random scramble moves from moveGenerator;
- user moves through a valid/ready handshake;
- undo of user moves from a history stack.
It also computes real solved detection and sits between the board I/O glue and the cubeState engine.

Parameters:
STICKER_W, 3, bits per sticker colour code
SCRAMBLE_LEN, 30, random moves applied per scramble, range 1..255
HIST_DEPTH, 16, undo history entries (power of 2, ≥2)
CNT_W, 16, width of the user move counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_scramble  in  1  single-cycle request to re-init to solved and scramble
move_valid  in  1  user move offered
move_face  in  3  user face 0..5
move_rot  in  2  0=none, 1=CW, 2=CCW, 3=double
move_ready  out  1  block accepts a user move this cycle
undo_req  in  1  single-cycle request to undo the last user move
rand_face  in  3  moveGenerator face
rand_rot  in  2  moveGenerator rotation: 0=CW, 1=CCW, 2=double, 3=CW
eng_face  out  6  face to cubeState.nextFaceMove, zero-extended
eng_rot  out  3  quarter turns to cubeState.nextRotation: CW=1, CCW=3, double=2
cube_next  in  54*STICKER_W  cubeState.cubeStateNew
cube_state  out  54*STICKER_W  current cube, registered
solved  out  1  registered solved flag
busy  out  1  high in every state except READY
err  out  1  one-cycle pulse on a rejected request
move_count  out  CNT_W  net user moves since last scramble
hist_level  out  $clog2(HIST_DEPTH)+1  entries held in history

Behaviour:
- Reset (async, rst_n=0) puts the block in this state:
  - state INIT; cube_state=0; solved=0; err=0; move_count=0; hist_level=0.
  - move_ready=0; busy=1; eng_face=0; eng_rot=0.
- States:
  - INIT:
    - load solved cube: sticker i gets colour i/9 (face f occupies stickers 9f..9f+8);
    - clear history and move_count;
    - then go to VERIFY.
  - READY: priority is start_scramble > undo_req > move_valid.
    - start_scramble → INIT, with the scramble flag set so INIT proceeds to SCRAMBLE.
    - undo_req with hist_level=0 → err pulse, stay in READY.
    - undo_req otherwise → pop the top entry, latch its inverse (CW↔CCW, double unchanged), go to APPLY.
    - move_ready = (state==READY) & !start_scramble & !undo_req.
    - A move is accepted when move_valid & move_ready at a clock edge.
    - Accepted move with move_face>5 → err pulse, no change, stay in READY.
    - Accepted move with move_rot=0 → accepted and consumed, no cube change, not pushed.
    - Any other accepted move → latch face/rot, go to APPLY.
  - APPLY (1 cycle):
    - eng_* driven from the latched move; cube_state <= cube_next.
    - User move: push to history; move_count+1, saturating.
    - Undo: move_count-1, floor 0.
    - Then go to VERIFY.
  - SCRAMBLE:
    - eng_* driven combinationally from rand_face/rand_rot.
    - Each cycle with rand_face≤5: cube_state <= cube_next and the scramble counter increments.
    - A cycle with rand_face>5 is a no-op and is not counted.
    - When the counter reaches SCRAMBLE_LEN → VERIFY; clear the scramble flag.
    - Scramble moves are never pushed to history.
    - Requests arriving during SCRAMBLE are ignored and produce no err.
  - VERIFY (1 cycle): solved <= checker output on cube_state, then go to READY.
- Latency:
  - User move accepted at edge T0 → cube_state updated at T1, solved at T2, move_ready high again in the cycle after T2.
  - Scramble takes SCRAMBLE_LEN valid cycles, plus INIT and VERIFY.
- History:
  - Circular LIFO of {face[2:0], rot[1:0]}.
  - Push when full overwrites the oldest entry; hist_level stays at HIST_DEPTH.
  - Pop decrements hist_level.
- Solved:
  - 1 iff every sticker on each face equals that face's centre sticker (index 9f+4).
  - Result is independent of colour assignment.
- Outside READY, user requests (move_valid, undo_req, start_scramble) are ignored without err.
- Reset mid-SCRAMBLE or mid-APPLY aborts immediately to reset values; no partial cube update persists.

Decomposition:
- Shared package cube_pkg holds:
  - constants: NUM_FACES=6, STICKERS_PER_FACE=9, CUBE_STICKERS=54, face codes;
  - rotation encodings for both the user code (move_rot) and the quarter-turn count (eng_rot);
  - an inverse-rotation function;
  - the state enum.
- One sub-module: cube_solved_check, combinational, parametrised by STICKER_W. Input is the cube vector, output is solved.
- The history stack stays inline.

Test Plan:
- Reset, then idle → after INIT+VERIFY: solved=1, cube_state has sticker i = i/9, move_ready=1, hist_level=0.
- User move face 0 CW, with a bench model of cube_next → cube_state changes at T1, solved=0 at T2, move_count=1, hist_level=1; then undo → engine sees eng_rot=3 on face 0, solved=1, move_count=0.
- start_scramble with SCRAMBLE_LEN=30 and rand_face forced to 7 on 5 cycles → exactly 30 applied moves, 35 SCRAMBLE cycles, history and move_count cleared, busy high throughout.
- HIST_DEPTH=4: 6 distinct moves then 5 undos → first 4 undos apply the inverses of moves 6..3, 5th undo pulses err; hist_level sequence 4,3,2,1,0,0.
- Boundaries: move_face=6 → err and no cube change; move_rot=0 → consumed, no change, hist unchanged; start_scramble+undo_req+move_valid in the same cycle → scramble only, move_ready=0 in that cycle.
- Assert rst_n in the APPLY cycle → cube_state=0, state INIT, then solved cube restored; no history entry survives.
